// File: rtl/xor_burst_arbiter_if.sv
// Bundle of request, data-beat and result signals between N requesters and the
// shared XOR burst arbiter.
interface xor_burst_arbiter_if #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int LENW = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]      req;
  logic [N*LENW-1:0] len;
  logic [N*W-1:0]    data;
  logic [N-1:0]      dvalid;
  logic [N-1:0]      dready;
  logic [N-1:0]      gnt;
  logic [W-1:0]      res;
  logic [IDW-1:0]    res_id;
  logic              res_valid;
  logic              res_ready;
  logic              busy;

  modport master (
    output req, len, data, dvalid, res_ready,
    input  dready, gnt, res, res_id, res_valid, busy
  );

  modport slave (
    input  req, len, data, dvalid, res_ready,
    output dready, gnt, res, res_id, res_valid, busy
  );
endinterface

// File: rtl/xor_burst_arbiter.sv
// Round-robin scheduler that lends one W-bit XOR accumulator to N requesters,
// one burst at a time, and returns the checksum with the winner's index.
module xor_burst_arbiter #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int LENW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  xor_burst_arbiter_if.slave    bus
);
  localparam int IDW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_gntIdx;
  logic [N-1:0]    r_gnt;
  logic [LENW-1:0] r_remaining;
  logic [W-1:0]    r_acc;

  logic [IDW-1:0]  w_pickIdx;
  logic            w_pickFound;
  logic [LENW-1:0] w_pickLen;
  logic [W-1:0]    w_dataG;
  logic            w_beat;
  logic            w_resFire;

  // First pending request at or above the pointer, wrapping modulo N.
  always_comb begin : pickProc
    int k;
    k           = 0;
    w_pickFound = 1'b0;
    w_pickIdx   = '0;
    for (int i = 0; i < N; i++) begin
      k = (int'(r_ptr) + i) % N;
      if (!w_pickFound && bus.req[k]) begin
        w_pickFound = 1'b1;
        w_pickIdx   = IDW'(k);
      end
    end
  end

  assign w_pickLen = bus.len[w_pickIdx*LENW +: LENW];
  assign w_dataG   = bus.data[r_gntIdx*W +: W];
  assign w_beat    = (r_state == ACCUM) && bus.dvalid[r_gntIdx];
  assign w_resFire = (r_state == DONE) && bus.res_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_pickFound) w_stateNext = (w_pickLen == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (w_beat && (r_remaining == LENW'(1))) w_stateNext = DONE;
      end
      DONE: begin
        if (bus.res_ready) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_gntIdx    <= '0;
      r_gnt       <= '0;
      r_remaining <= '0;
      r_acc       <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pickFound) begin
            r_gntIdx    <= w_pickIdx;
            r_gnt       <= {{(N-1){1'b0}}, 1'b1} << w_pickIdx;
            r_remaining <= w_pickLen;
            r_acc       <= '0;
          end
        end
        ACCUM: begin
          if (w_beat) begin
            r_acc       <= r_acc ^ w_dataG;
            r_remaining <= r_remaining - LENW'(1);
          end
        end
        DONE: begin
          if (w_resFire) begin
            r_ptr <= (r_gntIdx == IDW'(N-1)) ? '0 : r_gntIdx + IDW'(1);
            r_gnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Every handshake output is decoded from registers only.
  assign bus.gnt       = r_gnt;
  assign bus.dready    = (r_state == ACCUM) ? r_gnt : '0;
  assign bus.res       = r_acc;
  assign bus.res_id    = r_gntIdx;
  assign bus.res_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_xor_burst_arbiter.sv
// Directed bench for xor_burst_arbiter: bursts are driven in sequence and their
// expected checksums queued, then matched against each result handshake.
module tb_xor_burst_arbiter;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int LENW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xor_burst_arbiter_if #(.N(N), .W(W), .LENW(LENW)) bus ();

  xor_burst_arbiter #(.N(N), .W(W), .LENW(LENW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int           id;
    logic [W-1:0] res;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] expAcc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_gnt"},      bus.gnt,       0);
    checkOutput({tag, "_dready"},   bus.dready,    0);
    checkOutput({tag, "_resValid"}, bus.res_valid, 0);
    checkOutput({tag, "_res"},      bus.res,       0);
    checkOutput({tag, "_resId"},    bus.res_id,    0);
    checkOutput({tag, "_busy"},     bus.busy,      0);
  endtask

  task automatic waitGrant(input int id);
    int n;
    n = 0;
    while (bus.gnt == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("grant", bus.gnt, 32'(1) << id);
  endtask

  task automatic noiseOthers(input int id);
    for (int k = 0; k < N; k++) begin
      if (k != id) begin
        bus.dvalid[k]       = 1'($urandom_range(0, 1));
        bus.data[k*W +: W]  = W'($urandom);
      end
    end
  endtask

  // One data beat for requester id, preceded by gap idle cycles.
  task automatic applyStimulus(input int id, input logic [W-1:0] val, input int gap, input bit noise);
    repeat (gap) begin
      bus.dvalid[id] = 1'b0;
      if (noise) noiseOthers(id);
      @(negedge clk);
      checkOutput("dreadyStall", bus.dready, 32'(1) << id);
    end
    bus.data[id*W +: W] = val;
    bus.dvalid[id]      = 1'b1;
    if (noise) noiseOthers(id);
    checkOutput("dreadyBeat", bus.dready, 32'(1) << id);
    @(negedge clk);
    bus.dvalid[id] = 1'b0;
    expAcc = expAcc ^ val;
  endtask

  task automatic pushExpected(input int id);
    exp_t e;
    e.id  = id;
    e.res = expAcc;
    sbq.push_back(e);
  endtask

  task automatic getResult(input int holdCycles);
    int   n;
    exp_t e;
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("resValid", bus.res_valid, 1);
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sbq.pop_front();
    repeat (holdCycles) begin
      @(negedge clk);
      checkOutput("holdValid", bus.res_valid, 1);
      checkOutput("holdRes",   bus.res,       e.res);
      checkOutput("holdId",    bus.res_id,    e.id);
      checkOutput("holdGnt",   bus.gnt,       32'(1) << e.id);
    end
    bus.res_ready = 1'b1;
    checkOutput("res",     bus.res,    e.res);
    checkOutput("resId",   bus.res_id, e.id);
    checkOutput("gntHeld", bus.gnt,    32'(1) << e.id);
    @(negedge clk);
    bus.res_ready = 1'b0;
    checkOutput("validDrop", bus.res_valid, 0);
    checkOutput("busyGap",   bus.busy,      0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rr[5];
    rr = '{0, 1, 2, 3, 0};

    bus.req       = '0;
    bus.len       = '0;
    bus.data      = '0;
    bus.dvalid    = '0;
    bus.res_ready = 1'b0;
    expAcc        = '0;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(negedge clk);

    // Round-robin with every requester asking continuously.
    bus.len = {4'd1, 4'd1, 4'd1, 4'd1};
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      waitGrant(rr[i]);
      expAcc = '0;
      applyStimulus(rr[i], W'(8'h10 + i), 0, 1'b0);
      pushExpected(rr[i]);
      if (i == 4) bus.req = 4'b1000;
      getResult(0);
    end
    waitGrant(3);
    expAcc = '0;
    applyStimulus(3, 8'h3C, 0, 1'b0);
    pushExpected(3);
    bus.req = 4'b1001;
    getResult(0);
    waitGrant(0);
    bus.req = '0;
    expAcc  = '0;
    applyStimulus(0, 8'hC3, 0, 1'b0);
    pushExpected(0);
    getResult(0);

    // Single three-beat burst; request dropped right after grant.
    bus.len[1*LENW +: LENW] = 4'd3;
    bus.req = 4'b0010;
    waitGrant(1);
    bus.req = '0;
    expAcc  = '0;
    applyStimulus(1, 8'h0F, 0, 1'b0);
    applyStimulus(1, 8'hF0, 0, 1'b0);
    applyStimulus(1, 8'hAA, 0, 1'b0);
    pushExpected(1);
    checkOutput("resultLatency", bus.res_valid, 1);
    getResult(0);

    // Zero-length burst goes straight to the result.
    bus.len[2*LENW +: LENW] = 4'd0;
    bus.req = 4'b0100;
    waitGrant(2);
    bus.req = '0;
    checkOutput("zeroValid",  bus.res_valid, 1);
    checkOutput("zeroDready", bus.dready,    0);
    expAcc = '0;
    pushExpected(2);
    getResult(0);

    // Gap between beats, then result backpressure with another request pending.
    bus.len[3*LENW +: LENW] = 4'd2;
    bus.req = 4'b1000;
    waitGrant(3);
    bus.req = '0;
    expAcc  = '0;
    applyStimulus(3, 8'h11, 0, 1'b0);
    applyStimulus(3, 8'h22, 3, 1'b0);
    pushExpected(3);
    bus.len[0*LENW +: LENW] = 4'd3;
    bus.req = 4'b0001;
    getResult(5);

    // Neighbours toggle dvalid/data while requester 0 owns the datapath.
    waitGrant(0);
    bus.req = '0;
    expAcc  = '0;
    applyStimulus(0, 8'h01, 0, 1'b1);
    applyStimulus(0, 8'h80, 1, 1'b1);
    applyStimulus(0, 8'h7E, 0, 1'b1);
    pushExpected(0);
    getResult(0);
    bus.dvalid = '0;
    bus.data   = '0;

    // Reset after one of three beats discards the burst.
    bus.len[2*LENW +: LENW] = 4'd3;
    bus.req = 4'b0100;
    waitGrant(2);
    bus.req = '0;
    expAcc  = '0;
    applyStimulus(2, 8'h5A, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("midReset");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("noResultAfterReset", bus.res_valid, 0);

    bus.len[0*LENW +: LENW] = 4'd2;
    bus.req = 4'b0001;
    waitGrant(0);
    bus.req = '0;
    expAcc  = '0;
    applyStimulus(0, 8'h3C, 0, 1'b0);
    applyStimulus(0, 8'hC3, 0, 1'b0);
    pushExpected(0);
    getResult(0);

    checkOutput("sbDrained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
